// File: rtl/monster_engine.sv
// -----------------------------------------------------------------------------
// monster_engine
//   Game core for a hero standing in the middle of four lanes. Monsters are
//   spawned pseudo-randomly and walk toward the hero one step per movement
//   tick. A monster that reaches the hero either dies (the hero was attacking
//   in the right direction on the previous cycle) or costs a life. The game
//   ends when the lives run out.
//
// Ports
//   clk_game       in   sole clock, rising edge
//   rst            in   synchronous, active-high reset
//   start          in   level; a rising edge starts a new game from IDLE/OVER
//   move_tick      in   one-cycle movement strobe
//   pressing       in   attack button
//   state_hero     in   hero facing: 0 down, 1 up, 2 right, 3 left
//   alive          out  high while a game is being played
//   game_over      out  high after the last life is lost
//   score          out  kills in the current game (saturating)
//   lives          out  remaining lives
//   state_monsters out  packed slots, W=3+STEP_W bits each:
//                       {step, lane[1:0], active}
// -----------------------------------------------------------------------------
module monster_engine #(
    parameter int          MONSTERS     = 12,
    parameter int          STEPS        = 3,
    parameter int          STEP_W       = 2,
    parameter int          LIVES        = 3,
    parameter int          SPAWN_THRESH = 8,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic                               clk_game,
    input  logic                               rst,
    input  logic                               start,
    input  logic                               move_tick,
    input  logic                               pressing,
    input  logic [1:0]                         state_hero,
    output logic                               alive,
    output logic                               game_over,
    output logic [15:0]                        score,
    output logic [3:0]                         lives,
    output logic [MONSTERS*(3+STEP_W)-1:0]     state_monsters
);

    localparam int                W         = 3 + STEP_W;
    localparam int                CW        = $clog2(MONSTERS + 1);
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(STEPS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PLAY = 2'd1,
        S_OVER = 2'd2
    } state_t;

    state_t              r_state;
    logic                r_start_d;
    logic [15:0]         r_lfsr;
    logic                r_attack_valid;
    logic [1:0]          r_attack_dir;
    logic [MONSTERS-1:0] r_act;
    logic [1:0]          r_lane [MONSTERS];
    logic [STEP_W-1:0]   r_step [MONSTERS];
    logic [15:0]         r_score;
    logic [3:0]          r_lives;

    logic                w_start_rise;
    logic                w_tick;
    logic [15:0]         w_lfsr_next;
    logic [MONSTERS-1:0] w_act_n;
    logic [1:0]          w_lane_n [MONSTERS];
    logic [STEP_W-1:0]   w_step_n [MONSTERS];
    logic [CW-1:0]       w_kills;
    logic [CW-1:0]       w_misses;
    logic [1:0]          w_spawn_lane;
    logic                w_blocked;
    logic                w_taken;
    logic [16:0]         w_score_sum;
    logic [15:0]         w_score_n;
    logic [3:0]          w_lives_n;

    assign w_start_rise = start & ~r_start_d;
    assign w_tick       = move_tick & (r_state == S_PLAY);
    // Galois form, taps 16,14,13,11
    assign w_lfsr_next  = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
    assign w_spawn_lane = r_lfsr[5:4];

    // Movement, kill/miss accounting and spawn for one tick.
    always_comb begin
        w_act_n   = r_act;
        w_lane_n  = r_lane;
        w_step_n  = r_step;
        w_kills   = '0;
        w_misses  = '0;
        w_blocked = 1'b0;
        w_taken   = 1'b0;
        for (int i = 0; i < MONSTERS; i++) begin
            if (r_act[i]) begin
                if (r_step[i] == LAST_STEP) begin
                    // Monster at the hero: the attack latched last cycle decides it.
                    if (r_attack_valid && (r_attack_dir == (r_lane[i] ^ 2'b01)))
                        w_kills = w_kills + 1'b1;
                    else
                        w_misses = w_misses + 1'b1;
                    w_act_n[i]  = 1'b0;
                    w_lane_n[i] = '0;
                    w_step_n[i] = '0;
                end else begin
                    w_step_n[i] = r_step[i] + 1'b1;
                end
            end
        end
        for (int i = 0; i < MONSTERS; i++) begin
            if (w_act_n[i] && (w_lane_n[i] == w_spawn_lane) && (w_step_n[i] == '0))
                w_blocked = 1'b1;
        end
        // Only slots free before this tick are eligible, so a slot vacated
        // just now waits one tick before reuse.
        if (({1'b0, r_lfsr[3:0]} < 5'(SPAWN_THRESH)) && !w_blocked) begin
            for (int i = 0; i < MONSTERS; i++) begin
                if (!r_act[i] && !w_taken) begin
                    w_act_n[i]  = 1'b1;
                    w_lane_n[i] = w_spawn_lane;
                    w_step_n[i] = '0;
                    w_taken     = 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_score_sum = 17'(r_score) + 17'(w_kills);
        w_score_n   = w_score_sum[16] ? 16'hFFFF : w_score_sum[15:0];
        if (8'(w_misses) >= 8'(r_lives))
            w_lives_n = '0;
        else
            w_lives_n = 4'(8'(r_lives) - 8'(w_misses));
    end

    always_ff @(posedge clk_game) begin
        if (rst) begin
            r_state        <= S_IDLE;
            alive          <= 1'b0;
            game_over      <= 1'b0;
            r_score        <= '0;
            r_lives        <= '0;
            r_act          <= '0;
            r_attack_valid <= 1'b0;
            r_attack_dir   <= '0;
            r_lfsr         <= LFSR_SEED;
            // Primed with the live level so a start held through reset is not an edge.
            r_start_d      <= start;
            for (int i = 0; i < MONSTERS; i++) begin
                r_lane[i] <= '0;
                r_step[i] <= '0;
            end
        end else begin
            r_start_d      <= start;
            r_lfsr         <= w_lfsr_next;
            r_attack_valid <= (r_state == S_PLAY) & pressing;
            r_attack_dir   <= state_hero;
            case (r_state)
                S_IDLE, S_OVER: begin
                    if (w_start_rise) begin
                        r_state   <= S_PLAY;
                        alive     <= 1'b1;
                        game_over <= 1'b0;
                        r_score   <= '0;
                        r_lives   <= 4'(LIVES);
                        r_act     <= '0;
                        for (int i = 0; i < MONSTERS; i++) begin
                            r_lane[i] <= '0;
                            r_step[i] <= '0;
                        end
                    end
                end
                S_PLAY: begin
                    if (w_tick) begin
                        r_act   <= w_act_n;
                        r_lane  <= w_lane_n;
                        r_step  <= w_step_n;
                        r_score <= w_score_n;
                        r_lives <= w_lives_n;
                        if (w_lives_n == '0) begin
                            r_state   <= S_OVER;
                            alive     <= 1'b0;
                            game_over <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    alive     <= 1'b0;
                    game_over <= 1'b0;
                end
            endcase
        end
    end

    assign score = r_score;
    assign lives = r_lives;

    always_comb begin
        state_monsters = '0;
        for (int i = 0; i < MONSTERS; i++)
            state_monsters[i*W +: W] = {r_step[i], r_lane[i], r_act[i]};
    end

endmodule

// File: tb/tb_monster_engine.sv
module tb_monster_engine;

    localparam int W      = 5;
    localparam int NSTEPS = 3;
    localparam int NLIVES = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_v   [2];
    logic       start_v [2];
    logic       tick_v  [2];
    logic       press_v [2];
    logic [1:0] hero_v  [2];

    logic        a_alive, a_go, b_alive, b_go;
    logic [15:0] a_score, b_score;
    logic [3:0]  a_lives, b_lives;
    logic [59:0] a_mons;
    logic [9:0]  b_mons;

    monster_engine #(.MONSTERS(12), .STEPS(3), .STEP_W(2), .LIVES(3),
                     .SPAWN_THRESH(8), .LFSR_SEED(16'hACE1)) dut_a (
        .clk_game(clk), .rst(rst_v[0]), .start(start_v[0]), .move_tick(tick_v[0]),
        .pressing(press_v[0]), .state_hero(hero_v[0]), .alive(a_alive),
        .game_over(a_go), .score(a_score), .lives(a_lives), .state_monsters(a_mons));

    monster_engine #(.MONSTERS(2), .STEPS(3), .STEP_W(2), .LIVES(3),
                     .SPAWN_THRESH(16), .LFSR_SEED(16'hACE1)) dut_b (
        .clk_game(clk), .rst(rst_v[1]), .start(start_v[1]), .move_tick(tick_v[1]),
        .pressing(press_v[1]), .state_hero(hero_v[1]), .alive(b_alive),
        .game_over(b_go), .score(b_score), .lives(b_lives), .state_monsters(b_mons));

    // ---------------- behavioural game model, one per instance ----------------
    int P_M  [2] = '{12, 2};
    int P_TH [2] = '{8, 16};

    int ms     [2];   // 0 idle, 1 play, 2 over
    int mlfsr  [2];
    int mscore [2];
    int mlives [2];
    bit mav    [2];
    int mad    [2];
    bit msd    [2];
    bit mact   [2][32];
    int mlane  [2][32];
    int mstp   [2][32];

    int n_cmp = 0;
    int n_bad = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic clear_slots(input int k);
        for (int i = 0; i < 32; i++) begin
            mact[k][i] = 1'b0; mlane[k][i] = 0; mstp[k][i] = 0;
        end
    endtask

    task automatic model_step(input int k);
        int nl, kills, misses, lane, oldst;
        bit wasfree [32];
        bit blocked, taken, rise;
        nl = (mlfsr[k] >> 1) ^ (((mlfsr[k] & 1) != 0) ? 32'hB400 : 32'h0);
        if (rst_v[k]) begin
            ms[k] = 0; mscore[k] = 0; mlives[k] = 0; mav[k] = 1'b0; mad[k] = 0;
            msd[k] = start_v[k]; mlfsr[k] = 32'hACE1;
            clear_slots(k);
        end else begin
            rise = start_v[k] && !msd[k];
            msd[k] = start_v[k];
            oldst = ms[k];
            if (ms[k] != 1) begin
                if (rise) begin
                    ms[k] = 1; mscore[k] = 0; mlives[k] = NLIVES;
                    clear_slots(k);
                end
            end else if (tick_v[k]) begin
                kills = 0; misses = 0;
                for (int i = 0; i < P_M[k]; i++) wasfree[i] = !mact[k][i];
                for (int i = 0; i < P_M[k]; i++) begin
                    if (mact[k][i]) begin
                        if (mstp[k][i] < NSTEPS - 1) mstp[k][i] = mstp[k][i] + 1;
                        else begin
                            if (mav[k] && mad[k] == (mlane[k][i] ^ 1)) kills++;
                            else misses++;
                            mact[k][i] = 1'b0; mlane[k][i] = 0; mstp[k][i] = 0;
                        end
                    end
                end
                lane = (mlfsr[k] >> 4) & 3;
                blocked = 1'b0;
                for (int i = 0; i < P_M[k]; i++)
                    if (mact[k][i] && mlane[k][i] == lane && mstp[k][i] == 0) blocked = 1'b1;
                if ((mlfsr[k] & 15) < P_TH[k] && !blocked) begin
                    taken = 1'b0;
                    for (int i = 0; i < P_M[k]; i++) begin
                        if (wasfree[i] && !taken) begin
                            mact[k][i] = 1'b1; mlane[k][i] = lane; mstp[k][i] = 0; taken = 1'b1;
                        end
                    end
                end
                mscore[k] = (mscore[k] + kills > 65535) ? 65535 : mscore[k] + kills;
                mlives[k] = (misses >= mlives[k]) ? 0 : mlives[k] - misses;
                if (mlives[k] == 0) ms[k] = 2;
            end
            mav[k] = (oldst == 1) && press_v[k];
            mad[k] = int'(hero_v[k]);
            mlfsr[k] = nl;
        end
    endtask

    function automatic logic [63:0] mpack(input int k);
        logic [63:0] v;
        v = '0;
        for (int i = 0; i < P_M[k]; i++) begin
            if (mact[k][i]) begin
                v[i*W]        = 1'b1;
                v[i*W+1 +: 2] = 2'(mlane[k][i]);
                v[i*W+3 +: 2] = 2'(mstp[k][i]);
            end
        end
        return v;
    endfunction

    always @(posedge clk) begin
        model_step(0);
        model_step(1);
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (cmp_en) begin
            int n_act;
            int cnt0;
            bit ok;
            chk("a_alive", 64'(a_alive), 64'(ms[0] == 1));
            chk("a_game_over", 64'(a_go), 64'(ms[0] == 2));
            chk("a_score", 64'(a_score), 64'(mscore[0]));
            chk("a_lives", 64'(a_lives), 64'(mlives[0]));
            chk("a_monsters", 64'(a_mons), mpack(0));
            chk("b_alive", 64'(b_alive), 64'(ms[1] == 1));
            chk("b_game_over", 64'(b_go), 64'(ms[1] == 2));
            chk("b_score", 64'(b_score), 64'(mscore[1]));
            chk("b_lives", 64'(b_lives), 64'(mlives[1]));
            chk("b_monsters", 64'(b_mons), mpack(1));
            n_act = 0;
            ok = 1'b1;
            for (int i = 0; i < 2; i++) if (b_mons[i*W]) n_act++;
            for (int l = 0; l < 4; l++) begin
                cnt0 = 0;
                for (int i = 0; i < 2; i++)
                    if (b_mons[i*W] && b_mons[i*W+1 +: 2] == 2'(l) && b_mons[i*W+3 +: 2] == 2'd0)
                        cnt0++;
                if (cnt0 > 1) ok = 1'b0;
            end
            chk("b_max_active", 64'(n_act <= 2), 64'd1);
            chk("b_step0_lane_unique", 64'(ok), 64'd1);
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Issue one tick on a cycle where the model LFSR gives the wanted outcome:
    // want<0 -> no spawn, want 0..3 -> spawn into that lane.
    task automatic tick_when(input int k, input int want);
        bit done;
        bit hit;
        done = 1'b0;
        for (int c = 0; c < 3000 && !done; c++) begin
            if (want < 0) hit = (mlfsr[k] & 15) >= P_TH[k];
            else          hit = ((mlfsr[k] & 15) < P_TH[k]) && (((mlfsr[k] >> 4) & 3) == want);
            if (hit) begin
                tick_v[k] = 1'b1;
                cyc(1);
                tick_v[k] = 1'b0;
                done = 1'b1;
            end else begin
                cyc(1);
            end
        end
        if (!done) chk("tick_when_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        bit fin;
        for (int k = 0; k < 2; k++) begin
            rst_v[k] = 1'b1; start_v[k] = 1'b0; tick_v[k] = 1'b0;
            press_v[k] = 1'b0; hero_v[k] = 2'd0;
        end
        cyc(2);
        cmp_en = 1'b1;
        chk("lit_reset_alive", 64'(a_alive), 64'd0);
        chk("lit_reset_game_over", 64'(a_go), 64'd0);
        chk("lit_reset_score", 64'(a_score), 64'd0);
        chk("lit_reset_lives", 64'(a_lives), 64'd0);
        chk("lit_reset_monsters", 64'(a_mons), 64'd0);
        chk("lit_model_lfsr_seed", 64'(mlfsr[0]), 64'hACE1);
        rst_v[0] = 1'b0; rst_v[1] = 1'b0;
        cyc(1);
        chk("lit_model_lfsr_step", 64'(mlfsr[0]), 64'hE270);

        // start edge -> play on next edge
        start_v[0] = 1'b1;
        cyc(1);
        chk("lit_start_alive", 64'(a_alive), 64'd1);
        chk("lit_start_lives", 64'(a_lives), 64'd3);
        chk("lit_start_score", 64'(a_score), 64'd0);
        chk("lit_start_monsters", 64'(a_mons), 64'd0);

        // lane-2 monster walks in, hero attacks left -> kill
        tick_when(0, 2);
        tick_when(0, -1);
        tick_when(0, -1);
        chk("lit_lane2_at_hero", 64'(a_mons), 64'h15);
        hero_v[0] = 2'd3; press_v[0] = 1'b1;
        cyc(1);
        tick_when(0, -1);
        press_v[0] = 1'b0;
        chk("lit_kill_score", 64'(a_score), 64'd1);
        chk("lit_kill_lives", 64'(a_lives), 64'd3);
        chk("lit_kill_monsters", 64'(a_mons), 64'd0);

        // same without attack -> miss
        tick_when(0, 2);
        tick_when(0, -1);
        tick_when(0, -1);
        tick_when(0, -1);
        chk("lit_miss_lives", 64'(a_lives), 64'd2);
        chk("lit_miss_score", 64'(a_score), 64'd1);
        chk("lit_miss_monsters", 64'(a_mons), 64'd0);

        // keep ticking unarmed until the game ends
        fin = 1'b0;
        for (int c = 0; c < 300 && !fin; c++) begin
            tick_v[0] = 1'b1;
            cyc(1);
            fin = (ms[0] == 2);
        end
        tick_v[0] = 1'b0;
        if (!fin) chk("game_over_timeout", 64'd0, 64'd1);
        chk("lit_over_game_over", 64'(a_go), 64'd1);
        chk("lit_over_alive", 64'(a_alive), 64'd0);
        chk("lit_over_lives", 64'(a_lives), 64'd0);
        chk("lit_over_score", 64'(a_score), 64'd1);
        tick_v[0] = 1'b1;
        cyc(3);
        tick_v[0] = 1'b0;
        chk("lit_over_frozen_lives", 64'(a_lives), 64'd0);

        // restart from OVER, populate three lanes, then reset with start held
        start_v[0] = 1'b0;
        cyc(1);
        start_v[0] = 1'b1;
        cyc(1);
        chk("lit_restart_alive", 64'(a_alive), 64'd1);
        chk("lit_restart_game_over", 64'(a_go), 64'd0);
        chk("lit_restart_lives", 64'(a_lives), 64'd3);
        chk("lit_restart_score", 64'(a_score), 64'd0);
        tick_when(0, 0);
        tick_when(0, 1);
        tick_when(0, 3);
        chk("lit_three_monsters", 64'(a_mons), 64'h1D71);
        rst_v[0] = 1'b1;
        cyc(1);
        rst_v[0] = 1'b0;
        chk("lit_rst_alive", 64'(a_alive), 64'd0);
        chk("lit_rst_game_over", 64'(a_go), 64'd0);
        chk("lit_rst_score", 64'(a_score), 64'd0);
        chk("lit_rst_lives", 64'(a_lives), 64'd0);
        chk("lit_rst_monsters", 64'(a_mons), 64'd0);
        cyc(5);
        chk("lit_held_start_idle", 64'(a_alive), 64'd0);
        start_v[0] = 1'b0;
        cyc(1);
        start_v[0] = 1'b1;
        cyc(1);
        chk("lit_retoggle_alive", 64'(a_alive), 64'd1);
        chk("lit_retoggle_lives", 64'(a_lives), 64'd3);

        // two-slot instance, always spawning, hero defends every arrival
        start_v[1] = 1'b1;
        cyc(1);
        chk("lit_b_alive", 64'(b_alive), 64'd1);
        for (int t = 0; t < 10; t++) begin
            press_v[1] = 1'b0;
            for (int i = 0; i < 2; i++) begin
                if (mact[1][i] && mstp[1][i] == NSTEPS - 1) begin
                    hero_v[1]  = 2'(mlane[1][i] ^ 1);
                    press_v[1] = 1'b1;
                end
            end
            cyc(1);
            tick_v[1] = 1'b1;
            cyc(1);
            tick_v[1] = 1'b0;
        end
        press_v[1] = 1'b0;
        chk("lit_b_score", 64'(b_score), 64'd4);
        chk("lit_b_lives", 64'(b_lives), 64'd3);

        cyc(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/monster_engine.md
MONSTER_ENGINE -- requirements
Module: monster_engine

Interface
REQ-001 SHALL have parameter MONSTERS, default 12, number of monster slots (1..32).
REQ-002 SHALL have parameter STEPS, default 3, positions per lane; the last position (STEPS-1) is adjacent to the hero.
REQ-003 SHALL have parameter STEP_W, default 2, step field width, with 2^STEP_W >= STEPS.
REQ-004 SHALL have parameter LIVES, default 3, lives loaded at game start (1..15).
REQ-005 SHALL have parameter SPAWN_THRESH, default 8, spawn probability numerator out of 16.
REQ-006 SHALL have parameter LFSR_SEED, default 16'hACE1, non-zero LFSR reset value.
REQ-007 SHALL have clk_game  in  1  sole clock; all logic on its rising edge.
REQ-008 SHALL have rst  in  1  synchronous, active-high reset.
REQ-009 SHALL have start  in  1  level input; its rising edge is detected internally.
REQ-010 SHALL have move_tick  in  1  one-cycle movement strobe in the clk_game domain.
REQ-011 SHALL have pressing  in  1  attack button.
REQ-012 SHALL have state_hero  in  2  hero facing: 0 down, 1 up, 2 right, 3 left.
REQ-013 SHALL have alive  out  1  high in PLAY only.
REQ-014 SHALL have game_over  out  1  high in OVER only.
REQ-015 SHALL have score  out  16  kills this game.
REQ-016 SHALL have lives  out  4  remaining lives.
REQ-017 SHALL have state_monsters  out  MONSTERS*(3+STEP_W)  packed slots; with W=3+STEP_W, slot i has bit i*W = active, [i*W+2:i*W+1] = lane, [i*W+W-1:i*W+3] = step.

Function
REQ-018 SHALL implement FSM IDLE/PLAY/OVER: IDLE->PLAY and OVER->PLAY on a start rising edge; PLAY->OVER on the cycle lives becomes 0; no other transitions.
REQ-019 On entry to PLAY, SHALL within the same clock edge clear all slots, clear score and load lives=LIVES.
REQ-020 SHALL keep a 16-bit Galois LFSR (taps 16,14,13,11) that advances every cycle; reset loads LFSR_SEED.
REQ-021 SHALL register attack each cycle in PLAY: attack_valid=pressing, attack_dir=state_hero; attack_valid SHALL be 0 outside PLAY.
REQ-022 Movement and spawn SHALL act only on cycles with move_tick=1 in PLAY; move_tick is ignored in IDLE, in OVER, and on the PLAY-entry cycle.
REQ-023 On a tick, an active slot with step<STEPS-1 SHALL increment step by 1.
REQ-024 On a tick, an active slot with step==STEPS-1 SHALL be cleared (active=0); it is a kill if attack_valid and attack_dir==lane^2'b01, otherwise a miss.
REQ-025 SHALL add the kill count of each tick to score, saturating at 16'hFFFF.
REQ-026 SHALL subtract the miss count of each tick from lives, saturating at 0; multiple misses on one tick are all counted.
REQ-027 Per tick, SHALL spawn at most one monster into the lowest-index slot that was inactive before the tick, when LFSR[3:0]<SPAWN_THRESH and no active slot holds lane=LFSR[5:4] with step 0 after movement.
REQ-028 A spawned slot SHALL get active=1, lane=LFSR[5:4], step=0 and SHALL NOT advance on its spawn tick.
REQ-029 A slot freed on the current tick SHALL NOT be reused until the next tick.
REQ-030 If no slot is free, the spawn SHALL be dropped silently.
REQ-031 On the PLAY->OVER transition, slots SHALL freeze; score and lives SHALL hold until the next start.
REQ-032 alive and game_over SHALL be registered and decoded from the FSM state.

Reset
REQ-033 rst SHALL force, on the next edge: state IDLE; alive=0, game_over=0, score=0, lives=0, state_monsters=0, attack_valid=0; LFSR=LFSR_SEED; start edge detector primed with the current start level.
REQ-034 rst mid-game SHALL abandon the game; a start held high through reset SHALL NOT trigger PLAY until it falls and rises again.

Verification
REQ-035 SHALL verify: reset, start 0->1 -> next cycle alive=1, lives=3, score=0, state_monsters=0.
REQ-036 SHALL verify: force one lane-2 monster, 3 ticks with pressing=1, state_hero=3 -> slot cleared, score=1, lives=3.
REQ-037 SHALL verify: same with pressing=0 -> slot cleared, lives=2, score=0.
REQ-038 SHALL verify: three monsters reach step 2 on one tick, no attack -> lives 3->0 on that tick, then game_over=1, alive=0.
REQ-039 SHALL verify: MONSTERS=2, SPAWN_THRESH=16, 10 ticks with correct attacks -> never more than 2 active, no two step-0 monsters share a lane.
REQ-040 SHALL verify: rst asserted with 5 active monsters and start held high -> all outputs 0, state IDLE, no PLAY until start toggles.
